// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and draw-code helper for the pong match controller
package pong_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } pong_state_e;

  // A winner code equal to the player count means nobody finished strictly ahead.
  function automatic int draw_code(input int num_players);
    return num_players;
  endfunction

endpackage

// File: rtl/pong_countdown.sv
// rtl/pong_countdown.sv - loadable down-counter that stops at zero and flags it
module pong_countdown #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - match sequencer for a multi-player pong game
// Serve delay, round timer, scoring and winner selection; all outputs registered.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int ROUND_SEC   = 120,
  parameter int SERVE_CYC   = 200
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pause,
  input  logic                               tick_1s,
  input  logic [NUM_PLAYERS-1:0]             miss,
  output logic [NUM_PLAYERS*SCORE_W-1:0]     scores,
  output logic [$clog2(ROUND_SEC+1)-1:0]     time_left,
  output logic                               stop,
  output logic                               ball_reset,
  output logic [STATE_W-1:0]                 state,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]   winner,
  output logic                               game_over
);

  localparam int TIME_W = $clog2(ROUND_SEC + 1);
  localparam int WIN_W  = $clog2(NUM_PLAYERS + 1);
  localparam int SRV_W  = $clog2(SERVE_CYC + 1);
  localparam logic [WIN_W-1:0]   DRAW    = WIN_W'(draw_code(NUM_PLAYERS));
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  pong_state_e                      state_q, state_d;
  logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
  logic [WIN_W-1:0]                 winner_q, winner_d;
  logic                             ball_reset_q, ball_reset_d;
  logic                             stop_q, game_over_q;

  logic                             serve_load, serve_zero;
  logic [SRV_W-1:0]                 serve_cnt_unused;
  logic                             time_zero, timeout, win_hit;
  logic [SCORE_W-1:0]               best_val;
  logic [WIN_W-1:0]                 best_idx;
  logic                             best_unique;

  pong_countdown #(
    .W       (SRV_W),
    .RST_VAL ('0)
  ) u_serve_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (serve_load),
    .load_val (SRV_W'(SERVE_CYC - 1)),
    .en       (state_q == ST_SERVE),
    .count    (serve_cnt_unused),
    .zero     (serve_zero)
  );

  // Reloading whenever the next state is IDLE keeps time_left at full length there.
  pong_countdown #(
    .W       (TIME_W),
    .RST_VAL (TIME_W'(ROUND_SEC))
  ) u_round_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_d == ST_IDLE),
    .load_val (TIME_W'(ROUND_SEC)),
    .en       (tick_1s && (state_q == ST_PLAY)),
    .count    (time_left),
    .zero     (time_zero)
  );

  assign timeout = time_zero || (tick_1s && (time_left == TIME_W'(1)));

  always_comb begin
    state_d      = state_q;
    scores_d     = scores_q;
    ball_reset_d = 1'b0;
    serve_load   = 1'b0;
    win_hit      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SERVE;
          ball_reset_d = 1'b1;
          serve_load   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (serve_zero) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (|miss) begin
          ball_reset_d = 1'b1;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!miss[i] && (scores_q[i*SCORE_W +: SCORE_W] != WIN_VAL))
              scores_d[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + 1'b1;
          end
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scores_d[i*SCORE_W +: SCORE_W] == WIN_VAL) win_hit = 1'b1;
          end
          if (win_hit || timeout) begin
            state_d = ST_OVER;
          end else begin
            state_d    = ST_SERVE;
            serve_load = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (start) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) scores_d = '0;
  end

  // Winner is decided from the final scores on the cycle OVER is entered, then held.
  always_comb begin
    best_val    = scores_d[SCORE_W-1:0];
    best_idx    = '0;
    best_unique = 1'b1;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_d[i*SCORE_W +: SCORE_W] > best_val) begin
        best_val    = scores_d[i*SCORE_W +: SCORE_W];
        best_idx    = WIN_W'(i);
        best_unique = 1'b1;
      end else if (scores_d[i*SCORE_W +: SCORE_W] == best_val) begin
        best_unique = 1'b0;
      end
    end
    if (state_d != ST_OVER)      winner_d = DRAW;
    else if (state_q == ST_OVER) winner_d = winner_q;
    else                         winner_d = best_unique ? best_idx : DRAW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      scores_q     <= '0;
      winner_q     <= DRAW;
      ball_reset_q <= 1'b0;
      stop_q       <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scores_q     <= scores_d;
      winner_q     <= winner_d;
      ball_reset_q <= ball_reset_d;
      stop_q       <= (state_d != ST_PLAY);
      game_over_q  <= (state_d == ST_OVER);
    end
  end

  assign scores     = scores_q;
  assign stop       = stop_q;
  assign ball_reset = ball_reset_q;
  assign state      = state_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl
// A match-level model is compared every cycle; directed literals pin key scenarios.
module tb_pong_match_ctrl;

  localparam int NP = 2, SW = 4, WIN = 7, RS = 3, SC = 200;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, PAUSED = 3, OVER = 4;

  logic            clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, tick_1s = 1'b0;
  logic [NP-1:0]   miss = '0;
  logic [NP*SW-1:0] scores;
  logic [1:0]      time_left;
  logic            stop, ball_reset, game_over;
  logic [2:0]      state;
  logic [1:0]      winner;

  int errors = 0, checks = 0;

  int m_mode, m_time, m_serve_left, m_winner;
  int m_score[NP];
  bit m_br;

  pong_match_ctrl #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN), .ROUND_SEC(RS), .SERVE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .tick_1s(tick_1s), .miss(miss),
    .scores(scores), .time_left(time_left), .stop(stop), .ball_reset(ball_reset),
    .state(state), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = IDLE; m_time = RS; m_serve_left = 0; m_winner = NP; m_br = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endtask

  function automatic int m_pick_winner();
    int best = -1, who = NP, ties = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_score[i] > best) begin best = m_score[i]; who = i; ties = 1; end
      else if (m_score[i] == best) ties++;
    end
    return (ties == 1) ? who : NP;
  endfunction

  function automatic int m_packed_scores();
    int v = 0;
    for (int i = 0; i < NP; i++) v += m_score[i] << (SW * i);
    return v;
  endfunction

  // Advances the model by one clock using the inputs that the next edge will sample.
  task automatic m_step();
    bit final_tick, won;
    m_br = 0;
    case (m_mode)
      IDLE: if (start) begin m_mode = SERVE; m_br = 1; m_serve_left = SC; end
      SERVE: begin
        m_serve_left--;
        if (m_serve_left == 0) m_mode = PLAY;
      end
      PLAY: begin
        final_tick = tick_1s && (m_time == 1);
        if (tick_1s && m_time > 0) m_time--;
        if (miss != 0) begin
          m_br = 1;
          won  = 0;
          for (int i = 0; i < NP; i++) begin
            if (!miss[i] && m_score[i] < WIN) m_score[i]++;
            if (m_score[i] == WIN) won = 1;
          end
          if (won || final_tick) begin m_mode = OVER; m_winner = m_pick_winner(); end
          else begin m_mode = SERVE; m_serve_left = SC; end
        end else if (final_tick) begin
          m_mode = OVER; m_winner = m_pick_winner();
        end else if (pause) begin
          m_mode = PAUSED;
        end
      end
      PAUSED: if (start) m_mode = PLAY;
      OVER: if (start) begin
        m_mode = IDLE; m_time = RS; m_winner = NP;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
      end
      default: m_mode = IDLE;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_reset();
      end else begin
        chk("cmp_state", int'(state), m_mode);
        chk("cmp_scores", int'(scores), m_packed_scores());
        chk("cmp_time_left", int'(time_left), m_time);
        chk("cmp_stop", int'(stop), (m_mode != PLAY) ? 1 : 0);
        chk("cmp_ball_reset", int'(ball_reset), int'(m_br));
        chk("cmp_winner", int'(winner), m_winner);
        chk("cmp_game_over", int'(game_over), (m_mode == OVER) ? 1 : 0);
        m_step();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin cyc(1); n++; end
    chk("wait_state", int'(state), s);
  endtask

  task automatic pulse(input logic [NP-1:0] m, input logic t, input logic p);
    miss = m; tick_1s = t; pause = p;
    cyc(1);
    miss = '0; tick_1s = 1'b0; pause = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state), IDLE);
    chk({tag, "_scores"}, int'(scores), 0);
    chk({tag, "_time"}, int'(time_left), RS);
    chk({tag, "_stop"}, int'(stop), 1);
    chk({tag, "_ball_reset"}, int'(ball_reset), 0);
    chk({tag, "_winner"}, int'(winner), NP);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    cyc(2);
    chk_reset_outputs("por");
    rst = 1'b1;
    cyc(1);

    // Start: ball_reset one cycle after start, PLAY exactly SC cycles after SERVE entry.
    press_start();
    chk("serve_entry", int'(state), SERVE);
    chk("serve_ball_reset", int'(ball_reset), 1);
    cyc(1);
    chk("ball_reset_single", int'(ball_reset), 0);
    cyc(SC - 2);
    chk("serve_last_cycle", int'(state), SERVE);
    chk("serve_stop", int'(stop), 1);
    cyc(1);
    chk("play_on_time", int'(state), PLAY);
    chk("play_stop_low", int'(stop), 0);

    // P0 misses: P1 scores.
    pulse(2'b01, 1'b0, 1'b0);
    chk("miss01_scores", int'(scores), 8'h10);
    chk("miss01_state", int'(state), SERVE);
    chk("miss01_ball_reset", int'(ball_reset), 1);
    wait_state(PLAY, SC + 10);

    for (int k = 0; k < 6; k++) begin
      pulse(2'b10, 1'b0, 1'b0);
      wait_state(PLAY, SC + 10);
    end
    chk("p0_six", int'(scores), 8'h16);
    pulse(2'b10, 1'b0, 1'b0);
    chk("win_scores", int'(scores), 8'h17);
    chk("win_state", int'(state), OVER);
    chk("win_winner", int'(winner), 0);
    chk("win_game_over", int'(game_over), 1);

    press_start();
    chk("over_to_idle", int'(state), IDLE);
    chk("idle_scores", int'(scores), 0);
    chk("idle_winner", int'(winner), NP);
    chk("idle_time", int'(time_left), RS);

    // Timeout with no misses ends in a draw.
    press_start();
    wait_state(PLAY, SC + 10);
    chk("to_time3", int'(time_left), 3);
    pulse(2'b00, 1'b1, 1'b0);
    chk("to_time2", int'(time_left), 2);
    pulse(2'b00, 1'b1, 1'b0);
    chk("to_time1", int'(time_left), 1);
    chk("to_still_play", int'(state), PLAY);
    pulse(2'b00, 1'b1, 1'b0);
    chk("to_time0", int'(time_left), 0);
    chk("to_state", int'(state), OVER);
    chk("to_winner_draw", int'(winner), NP);

    press_start();
    press_start();
    wait_state(PLAY, SC + 10);

    // Everyone misses: no score, but a new serve.
    pulse(2'b11, 1'b0, 1'b0);
    chk("allmiss_scores", int'(scores), 0);
    chk("allmiss_state", int'(state), SERVE);
    chk("allmiss_ball_reset", int'(ball_reset), 1);
    wait_state(PLAY, SC + 10);

    // Pause freezes the timer and ignores misses.
    pulse(2'b00, 1'b1, 1'b0);
    chk("pre_pause_time", int'(time_left), 2);
    pulse(2'b00, 1'b0, 1'b1);
    chk("paused_state", int'(state), PAUSED);
    chk("paused_stop", int'(stop), 1);
    for (int k = 0; k < 5; k++) begin
      pulse((k % 2 == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0);
      cyc(1);
    end
    chk("paused_time", int'(time_left), 2);
    chk("paused_scores", int'(scores), 0);
    press_start();
    chk("resume_state", int'(state), PLAY);
    chk("resume_time", int'(time_left), 2);

    // Miss, final tick and pause together: score, then OVER.
    pulse(2'b00, 1'b1, 1'b0);
    chk("pre_final_time", int'(time_left), 1);
    pulse(2'b01, 1'b1, 1'b1);
    chk("combo_scores", int'(scores), 8'h10);
    chk("combo_state", int'(state), OVER);
    chk("combo_time", int'(time_left), 0);
    chk("combo_winner", int'(winner), 1);
    cyc(3);
    chk("combo_stays_over", int'(state), OVER);

    // Asynchronous reset mid-PLAY.
    press_start();
    press_start();
    wait_state(PLAY, SC + 10);
    pulse(2'b10, 1'b0, 1'b0);
    wait_state(PLAY, SC + 10);
    pulse(2'b00, 1'b1, 1'b0);
    chk("prereset_scores", int'(scores), 8'h01);
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("post_reset_idle", int'(state), IDLE);
    press_start();
    chk("post_reset_serve", int'(state), SERVE);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of players (legal 2..4).
REQ-002 SHALL have parameter SCORE_W, default 4, width of each player score.
REQ-003 SHALL have parameter WIN_SCORE, default 7, score that ends the match (must be < 2**SCORE_W).
REQ-004 SHALL have parameter ROUND_SEC, default 120, match length in seconds.
REQ-005 SHALL have parameter SERVE_CYC, default 200, serve-delay length in clk cycles.
REQ-006 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-007 SHALL have port rst  in  1  reset: asynchronous, active-low.
REQ-008 SHALL have port start  in  1  level, sampled each clk; begins match, resumes from pause, and acknowledges game over.
REQ-009 SHALL have port pause  in  1  level pause request.
REQ-010 SHALL have port tick_1s  in  1  one-cycle strobe per second.
REQ-011 SHALL have port miss  in  NUM_PLAYERS  bit i = player i missed the ball this cycle.
REQ-012 SHALL have port scores  out  NUM_PLAYERS*SCORE_W  packed scores; player 0 in the LSBs.
REQ-013 SHALL have port time_left  out  $clog2(ROUND_SEC+1)  seconds remaining.
REQ-014 SHALL have port stop  out  1  freezes ball and paddle motion when 1.
REQ-015 SHALL have port ball_reset  out  1  one-cycle pulse that re-centres the ball.
REQ-016 SHALL have port state  out  3  current FSM state code.
REQ-017 SHALL have port winner  out  $clog2(NUM_PLAYERS+1)  winning player index; value NUM_PLAYERS means draw.
REQ-018 SHALL have port game_over  out  1  high while the FSM is in OVER.

Function
REQ-019 SHALL register every output; each output reflects an input event 1 cycle after that event is sampled.
REQ-020 SHALL implement states IDLE=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4.
REQ-021 In IDLE:
  - SHALL hold scores=0, time_left=ROUND_SEC, stop=1.
  - On start=1: go to SERVE and pulse ball_reset.
REQ-022 In SERVE:
  - SHALL hold stop=1 and count SERVE_CYC cycles.
  - SHALL then enter PLAY automatically; start and pause are ignored.
REQ-023 In PLAY:
  - SHALL drive stop=0.
  - SHALL decrement time_left by 1 on each tick_1s.
REQ-024 On any miss bit in PLAY:
  - Each non-missing player's score SHALL increment by 1, saturating at WIN_SCORE.
  - If all bits miss, no score changes.
  - ball_reset SHALL pulse.
  - Next state SHALL be OVER if any score reaches WIN_SCORE, else SERVE.
REQ-025 If time_left would reach 0 in PLAY, the FSM SHALL go to OVER.
REQ-026 Priority in PLAY SHALL be: miss > timeout > pause.
  - A miss and the final tick in the same cycle: score first, then OVER.
  - A pause in the same cycle as a miss is ignored.
REQ-027 In PAUSED:
  - SHALL hold stop=1, freeze time_left, ignore miss and tick_1s.
  - start=1 SHALL return to PLAY.
REQ-028 On entering OVER:
  - winner SHALL latch the index of the unique highest score, else NUM_PLAYERS.
  - game_over=1 and stop=1.
  - start=1 SHALL return to IDLE, clearing scores and winner.
REQ-029 In any state other than OVER, winner SHALL read NUM_PLAYERS.

Reset
REQ-030 On rst=0, asynchronously:
  - state=IDLE, scores=0, time_left=ROUND_SEC.
  - stop=1, ball_reset=0, game_over=0, winner=NUM_PLAYERS.
  - Serve counter=0.
REQ-031 Reset asserted mid-match SHALL abandon the match with no residual score or timer.

Structure
REQ-032 State encoding and the draw-code convention SHALL live in shared package pong_pkg.
REQ-033 The serve delay and the round timer SHALL each instantiate sub-module pong_countdown.
  - pong_countdown is a parametrised down-counter with load, enable, and zero flag.

Verification
REQ-034 Reset, start=1, wait 200 cycles -> ball_reset pulses 1 cycle after start; state=PLAY exactly 200 cycles after entering SERVE; stop falls with it.
REQ-035 PLAY, miss=2'b01 -> scores P1=1, P0=0, state=SERVE, ball_reset=1 for 1 cycle.
REQ-036 P0=6, miss=2'b10 -> P0=7, state=OVER, winner=0, game_over=1.
REQ-037 ROUND_SEC=3, no misses, 3 tick_1s -> time_left 3,2,1,0, then OVER with winner=2 (draw, scores 0:0).
REQ-038 Same cycle: miss=2'b01, final tick, and pause -> P1 scores, state=OVER, PAUSED never entered.
REQ-039 pause in PLAY, 5 ticks, then start -> time_left unchanged across the pause; rst low mid-PLAY -> all outputs at reset values immediately.
